pair_sum_datapath: RTL and testbench

- Datapath stage driven directly by the sequencing controller's IncA, IncB, WEA and WEB strobes.
- Holds memory A (input samples) and memory B (results), with an address counter for each.
- Streams memory A through a two-deep read pipeline and writes saturated sums of adjacent samples into memory B.
- Read-back port on memory B feeds downstream consumers.

---
 rtl/pair_sum_datapath.sv | 61 ++++++
 tb/tb_pair_sum_datapath.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pair_sum_datapath.sv
// Datapath for the pair-sum sequencer: streams memory A through a two-deep read pipeline
// and stores saturated sums of adjacent samples in memory B.
module pair_sum_datapath #(
  parameter int DW      = 8,
  parameter int DEPTH_A = 8,
  parameter int DEPTH_B = 4,
  localparam int AW     = $clog2(DEPTH_A),
  localparam int BW     = $clog2(DEPTH_B)
) (
  input  logic          clock,
  input  logic          Reset,
  input  logic          IncA,
  input  logic          WEA,
  input  logic          IncB,
  input  logic          WEB,
  input  logic [DW-1:0] DataIn,
  output logic [AW-1:0] AddrA,
  output logic [BW-1:0] AddrB,
  output logic [DW-1:0] RdA,
  output logic [DW-1:0] PrevA,
  output logic [DW-1:0] Sum,
  output logic [DW-1:0] DataOutB,
  output logic          SatFlag
);

  logic [DW-1:0] mem_a [DEPTH_A];
  logic [DW-1:0] mem_b [DEPTH_B];
  logic [DW:0]   wide_sum;
  logic          sat;

  always_comb begin
    wide_sum = {1'b0, RdA} + {1'b0, PrevA};
    sat      = wide_sum[DW];
    Sum      = sat ? '1 : wide_sum[DW-1:0];
  end

  // Memories share the reset-sensitive block so writes are inhibited during reset,
  // but their contents are never cleared.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      AddrA    <= '0;
      AddrB    <= '0;
      RdA      <= '0;
      PrevA    <= '0;
      DataOutB <= '0;
      SatFlag  <= 1'b0;
    end else begin
      if (WEA) mem_a[AddrA] <= DataIn;
      if (IncA) AddrA <= AddrA + AW'(1);
      RdA   <= mem_a[AddrA];
      PrevA <= RdA;
      if (WEB) begin
        mem_b[AddrB] <= Sum;
        if (sat) SatFlag <= 1'b1;
      end
      if (IncB) AddrB <= AddrB + BW'(1);
      DataOutB <= mem_b[AddrB];
    end
  end

endmodule

// File: tb/tb_pair_sum_datapath.sv
// Directed self-checking bench for pair_sum_datapath.
module tb_pair_sum_datapath;

  logic       clock = 1'b0;
  logic       Reset;
  logic       IncA, WEA, IncB, WEB;
  logic [7:0] DataIn;
  logic [2:0] AddrA;
  logic [1:0] AddrB;
  logic [7:0] RdA, PrevA, Sum, DataOutB;
  logic       SatFlag;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [7:0] sum_seen [4];
  logic       sat_seen [4];
  logic [7:0] rd_b     [4];
  logic [7:0] vals     [8];

  pair_sum_datapath #(.DW(8), .DEPTH_A(8), .DEPTH_B(4)) dut (
    .clock(clock), .Reset(Reset), .IncA(IncA), .WEA(WEA), .IncB(IncB), .WEB(WEB),
    .DataIn(DataIn), .AddrA(AddrA), .AddrB(AddrB), .RdA(RdA), .PrevA(PrevA),
    .Sum(Sum), .DataOutB(DataOutB), .SatFlag(SatFlag)
  );

  always #5 clock = ~clock;

  // One clock edge with the given strobes; returns 1 time unit after the edge.
  task automatic step(input logic inca, input logic wea, input logic incb,
                      input logic web, input logic [7:0] data);
    IncA = inca; WEA = wea; IncB = incb; WEB = web; DataIn = data;
    @(posedge clock);
    #1;
    IncA = 1'b0; WEA = 1'b0; IncB = 1'b0; WEB = 1'b0; DataIn = '0;
  endtask

  task automatic pulse_reset();
    Reset = 1'b0;
    #2;
    Reset = 1'b1;
  endtask

  task automatic load_a(input logic [7:0] v [8]);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 1'b0, v[i]);
  endtask

  // Controller strobe pattern: pairs appear two edges after their first sample is addressed.
  task automatic run_sums();
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int k = 0; k < 4; k++) begin
      sum_seen[k] = Sum;
      step(k < 3, 1'b0, 1'b1, 1'b1, '0);
      sat_seen[k] = SatFlag;
      if (k < 3) step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    end
  endtask

  task automatic read_b();
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, '0);
      rd_b[k] = DataOutB;
    end
  endtask

  task automatic test_reset();
    pulse_reset();
    total++;
    if ({AddrA, AddrB, RdA, PrevA, DataOutB, SatFlag} !== '0) begin
      bad++;
      $display("FAIL reset_state: got AddrA=%0d AddrB=%0d RdA=%0h PrevA=%0h DataOutB=%0h SatFlag=%0b, want all 0",
               AddrA, AddrB, RdA, PrevA, DataOutB, SatFlag);
    end
  endtask

  task automatic test_fill_sum();
    logic [7:0] exp_b [4];
    pulse_reset();
    vals  = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    exp_b = '{8'd3, 8'd7, 8'd11, 8'd15};
    load_a(vals);
    total++;
    if (AddrA !== 3'd0) begin bad++; $display("FAIL fill_addra: got %0d want 0", AddrA); end
    run_sums();
    total++;
    if (AddrB !== 2'd0) begin bad++; $display("FAIL fill_addrb: got %0d want 0", AddrB); end
    read_b();
    for (int k = 0; k < 4; k++) begin
      total++;
      if (sum_seen[k] !== exp_b[k]) begin bad++; $display("FAIL fill_sum[%0d]: got %0d want %0d", k, sum_seen[k], exp_b[k]); end
      total++;
      if (rd_b[k] !== exp_b[k]) begin bad++; $display("FAIL fill_memb[%0d]: got %0d want %0d", k, rd_b[k], exp_b[k]); end
    end
    total++;
    if (SatFlag !== 1'b0) begin bad++; $display("FAIL fill_satflag: got %0b want 0", SatFlag); end
  endtask

  task automatic test_saturation();
    pulse_reset();
    vals = '{8'd200, 8'd100, 8'd10, 8'd20, 8'd0, 8'd0, 8'd0, 8'd0};
    load_a(vals);
    run_sums();
    read_b();
    total++;
    if (rd_b[0] !== 8'd255) begin bad++; $display("FAIL sat_b0: got %0d want 255", rd_b[0]); end
    total++;
    if (rd_b[1] !== 8'd30) begin bad++; $display("FAIL sat_b1: got %0d want 30", rd_b[1]); end
    total++;
    if (sat_seen[0] !== 1'b1) begin bad++; $display("FAIL sat_flag_set: got %0b want 1", sat_seen[0]); end
    total++;
    if (sat_seen[1] !== 1'b1) begin bad++; $display("FAIL sat_flag_sticky: got %0b want 1", sat_seen[1]); end
  endtask

  task automatic test_boundary();
    pulse_reset();
    vals = '{8'd128, 8'd127, 8'd128, 8'd128, 8'd0, 8'd0, 8'd0, 8'd0};
    load_a(vals);
    run_sums();
    read_b();
    total++;
    if (rd_b[0] !== 8'd255) begin bad++; $display("FAIL bound_b0: got %0d want 255", rd_b[0]); end
    total++;
    if (sat_seen[0] !== 1'b0) begin bad++; $display("FAIL bound_nosat: got %0b want 0", sat_seen[0]); end
    total++;
    if (rd_b[1] !== 8'd255) begin bad++; $display("FAIL bound_b1: got %0d want 255", rd_b[1]); end
    total++;
    if (sat_seen[1] !== 1'b1) begin bad++; $display("FAIL bound_sat: got %0b want 1", sat_seen[1]); end
  endtask

  // Relies on A[3] = 128 left by test_boundary.
  task automatic test_collision();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    total++;
    if (AddrA !== 3'd3) begin bad++; $display("FAIL coll_addra: got %0d want 3", AddrA); end
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h55);
    total++;
    if (RdA !== 8'd128) begin bad++; $display("FAIL coll_old0: got %0h want 80", RdA); end
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'hAA);
    total++;
    if (RdA !== 8'h55) begin bad++; $display("FAIL coll_old1: got %0h want 55", RdA); end
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    total++;
    if (RdA !== 8'hAA) begin bad++; $display("FAIL coll_new: got %0h want aa", RdA); end
  endtask

  task automatic test_wrap();
    pulse_reset();
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, i < 5, 1'b0, '0);
    total++;
    if (AddrA !== 3'd1) begin bad++; $display("FAIL wrap_addra: got %0d want 1", AddrA); end
    total++;
    if (AddrB !== 2'd1) begin bad++; $display("FAIL wrap_addrb: got %0d want 1", AddrB); end
  endtask

  task automatic test_async_reset();
    pulse_reset();
    vals = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    load_a(vals);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b1, 1'b1, '0);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    total++;
    if ({AddrA, AddrB, RdA, PrevA} !== {3'd4, 2'd1, 8'd4, 8'd3}) begin
      bad++;
      $display("FAIL async_pre: got AddrA=%0d AddrB=%0d RdA=%0d PrevA=%0d want 4 1 4 3", AddrA, AddrB, RdA, PrevA);
    end
    Reset = 1'b0;
    #2;
    total++;
    if ({AddrA, AddrB, RdA, PrevA, DataOutB, SatFlag, Sum} !== '0) begin
      bad++;
      $display("FAIL async_clear: got AddrA=%0d AddrB=%0d RdA=%0h PrevA=%0h DataOutB=%0h SatFlag=%0b Sum=%0h want all 0",
               AddrA, AddrB, RdA, PrevA, DataOutB, SatFlag, Sum);
    end
    Reset = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    total++;
    if (DataOutB !== 8'd3) begin bad++; $display("FAIL async_memb_kept: got %0d want 3", DataOutB); end
    total++;
    if (RdA !== 8'd1) begin bad++; $display("FAIL async_mema_kept: got %0d want 1", RdA); end
  endtask

  initial begin
    Reset = 1'b0; IncA = 1'b0; WEA = 1'b0; IncB = 1'b0; WEB = 1'b0; DataIn = '0;
    #12;
    Reset = 1'b1;
    @(posedge clock);
    #1;
    test_reset();
    test_fill_sum();
    test_saturation();
    test_boundary();
    test_collision();
    test_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
